// File: rtl/mem_pkg.sv
// Shared definitions for the memory controller slice.
// Holds the default sizing constants, the channel index encoding used by the
// response pipeline, the response pipeline record and a ceil-log2 helper.
package mem_pkg;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_DEPTH     = 256;
    localparam int DEF_MAX_STALL = 3;

    // Channel owning an access in flight.
    localparam logic CH_I = 1'b0;
    localparam logic CH_D = 1'b1;

    // One entry of the response pipeline: what was granted last cycle.
    typedef struct packed {
        logic valid;  // an access was granted
        logic ch;     // owner channel (CH_I / CH_D)
        logic rd;     // the access was a read, so an rvalid is owed
        logic err;    // the access address was >= DEPTH
    } resp_t;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/spram.sv
// Single-port synchronous block RAM, one access per clock.
// Ports:
//   clk    rising-edge clock
//   en     access enable; nothing happens when low
//   we     write enable (qualified by en)
//   addr   word address, clog2(DEPTH) bits
//   wdata  write data
//   rdata  registered read data, valid the cycle after an enabled read
// Contents are not reset. The array relies on the block-RAM power-up
// state of all zeros.
module spram
    import mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int AW    = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Read-first: a write cycle returns the old word, which the controller
    // never forwards because writes owe no rvalid.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/memory_ctrl.sv
// Two-channel (instruction fetch / data load-store) controller in front of a
// single-port synchronous RAM.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   i_req/i_addr           instruction read request
//   i_gnt                  combinational grant to I this cycle
//   i_rvalid/i_rdata       I read response, one cycle after i_gnt
//   i_err                  I granted address was out of range (with rvalid)
//   d_req/d_we/d_addr/d_wdata  data request (read or write)
//   d_gnt                  combinational grant to D this cycle
//   d_rvalid/d_rdata       D read response, one cycle after a read grant
//   d_err                  D granted address was out of range (cycle after grant)
//
// Handshake: a requester raises req with stable addr/we/wdata and holds them
// until it sees gnt high in the same cycle; the access is taken at that
// cycle's rising edge. Dropping req before gnt cancels the request. Read
// responses are a single-cycle rvalid pulse with no back-pressure; rdata
// keeps its last value while rvalid is low.
module memory_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int MAX_STALL = DEF_MAX_STALL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              i_err
);

    localparam int AW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
    localparam int SW = (clog2(MAX_STALL + 1) < 1) ? 1 : clog2(MAX_STALL + 1);

    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic [SW-1:0]   STALL_MAX = SW'(MAX_STALL);

    logic              i_oor;
    logic              d_oor;
    logic              i_win;
    logic              d_win;
    logic [SW-1:0]     stall_cnt;

    logic              ram_en;
    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    resp_t             resp_d;
    resp_t             resp_q;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] i_hold;
    logic [DATA_W-1:0] d_hold;

    // Range check on the full address, not just the decoded low bits.
    assign i_oor = ({1'b0, i_addr} >= DEPTH_L);
    assign d_oor = ({1'b0, d_addr} >= DEPTH_L);

    // Arbiter: D has priority, except once I has lost MAX_STALL cycles in a
    // row. Grants are forced low during reset.
    always_comb begin
        i_win = 1'b0;
        d_win = 1'b0;
        if (!rst) begin
            if (i_req && (!d_req || (stall_cnt == STALL_MAX))) begin
                i_win = 1'b1;
            end else if (d_req) begin
                d_win = 1'b1;
            end
        end
    end

    assign i_gnt = i_win;
    assign d_gnt = d_win;

    // Counts consecutive cycles in which I asked and lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (!i_req || i_win) begin
            stall_cnt <= '0;
        end else if (stall_cnt != STALL_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // RAM port steering. Out-of-range accesses never touch the array, so a
    // wrapped low-bit alias cannot be corrupted.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = i_addr[AW-1:0];
        ram_wdata = d_wdata;
        if (i_win) begin
            ram_en   = !i_oor;
            ram_addr = i_addr[AW-1:0];
        end else if (d_win) begin
            ram_en   = !d_oor;
            ram_we   = d_we && !d_oor;
            ram_addr = d_addr[AW-1:0];
        end
    end

    spram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Response pipeline: records who owns the word appearing on ram_rdata.
    always_comb begin
        resp_d       = '0;
        resp_d.valid = i_win || d_win;
        resp_d.ch    = d_win ? CH_D : CH_I;
        resp_d.rd    = i_win || (d_win && !d_we);
        resp_d.err   = (i_win && i_oor) || (d_win && d_oor);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_q <= '0;
        end else begin
            resp_q <= resp_d;
        end
    end

    assign i_rvalid = resp_q.valid && (resp_q.ch == CH_I) && resp_q.rd;
    assign d_rvalid = resp_q.valid && (resp_q.ch == CH_D) && resp_q.rd;
    assign i_err    = resp_q.valid && (resp_q.ch == CH_I) && resp_q.err;
    assign d_err    = resp_q.valid && (resp_q.ch == CH_D) && resp_q.err;

    // Out-of-range reads return zero instead of whatever the RAM last held.
    assign read_data = resp_q.err ? '0 : ram_rdata;

    // The RAM output is shared, so each channel presents it only during its
    // own rvalid cycle and otherwise shows a captured copy.
    assign i_rdata = i_rvalid ? read_data : i_hold;
    assign d_rdata = d_rvalid ? read_data : d_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_hold <= '0;
            d_hold <= '0;
        end else begin
            if (i_rvalid) begin
                i_hold <= read_data;
            end
            if (d_rvalid) begin
                d_hold <= read_data;
            end
        end
    end

endmodule

// File: tb/tb_memory_ctrl.sv
// Directed bench for memory_ctrl: default 16-bit/256-word instance plus a
// 32-bit/1024-word instance. Inputs change on the falling edge; grants are
// checked 1 ns later, registered responses reflect the preceding rising edge.
module tb_memory_ctrl;

    logic        clk;
    logic        rst;

    // Default instance
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [15:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [15:0] d_rdata;
    logic        d_err;
    logic        i_err;

    // Wide instance
    logic        b_i_req;
    logic [15:0] b_i_addr;
    logic        b_i_gnt;
    logic        b_i_rvalid;
    logic [31:0] b_i_rdata;
    logic        b_d_req;
    logic        b_d_we;
    logic [15:0] b_d_addr;
    logic [31:0] b_d_wdata;
    logic        b_d_gnt;
    logic        b_d_rvalid;
    logic [31:0] b_d_rdata;
    logic        b_d_err;
    logic        b_i_err;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];

    memory_ctrl dut_a (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .i_err    (i_err)
    );

    memory_ctrl #(
        .DATA_W    (32),
        .ADDR_W    (16),
        .DEPTH     (1024),
        .MAX_STALL (3)
    ) dut_b (
        .clk      (clk),
        .rst      (rst),
        .i_req    (b_i_req),
        .i_addr   (b_i_addr),
        .i_gnt    (b_i_gnt),
        .i_rvalid (b_i_rvalid),
        .i_rdata  (b_i_rdata),
        .d_req    (b_d_req),
        .d_we     (b_d_we),
        .d_addr   (b_d_addr),
        .d_wdata  (b_d_wdata),
        .d_gnt    (b_d_gnt),
        .d_rvalid (b_d_rvalid),
        .d_rdata  (b_d_rdata),
        .d_err    (b_d_err),
        .i_err    (b_i_err)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Driver tasks: apply at falling edge, settle 1 ns.
    task automatic step_a(input logic ir, input logic [15:0] ia, input logic dr,
                          input logic dw, input logic [15:0] da, input logic [15:0] dd);
        @(negedge clk);
        i_req   = ir;
        i_addr  = ia;
        d_req   = dr;
        d_we    = dw;
        d_addr  = da;
        d_wdata = dd;
        #1;
    endtask

    task automatic step_b(input logic dr, input logic dw, input logic [15:0] da,
                          input logic [31:0] dd);
        @(negedge clk);
        b_d_req   = dr;
        b_d_we    = dw;
        b_d_addr  = da;
        b_d_wdata = dd;
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        i_req     = 1'b0;
        i_addr    = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        b_i_req   = 1'b0;
        b_i_addr  = '0;
        b_d_req   = 1'b0;
        b_d_we    = 1'b0;
        b_d_addr  = '0;
        b_d_wdata = '0;

        // ---- reset state: no grants, outputs cleared ----
        step_a(1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000);
        check("rst_i_gnt", 32'(i_gnt), 32'h0);
        check("rst_d_gnt", 32'(d_gnt), 32'h0);
        check("rst_i_rvalid", 32'(i_rvalid), 32'h0);
        check("rst_d_rvalid", 32'(d_rvalid), 32'h0);
        check("rst_i_rdata", 32'(i_rdata), 32'h0);
        check("rst_d_rdata", 32'(d_rdata), 32'h0);
        check("rst_errs", 32'({i_err, d_err}), 32'h0);
        step_a(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        rst = 1'b0;

        // ---- preload mem[k] = 0xA000+k, then write/read 0x0010 ----
        for (int k = 0; k < 8; k++) begin
            step_a(1'b0, 16'h0000, 1'b1, 1'b1, 16'(k), 16'hA000 + 16'(k));
            check("pre_d_gnt", 32'(d_gnt), 32'h1);
        end
        step_a(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
        check("wr10_d_gnt", 32'(d_gnt), 32'h1);
        check("wr_no_rvalid", 32'(d_rvalid), 32'h0);
        check("wr_no_err", 32'(d_err), 32'h0);
        step_a(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'h0000);
        check("rd10_d_gnt", 32'(d_gnt), 32'h1);
        step_a(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check("rd10_rvalid", 32'(d_rvalid), 32'h1);
        check("rd10_rdata", 32'(d_rdata), 32'hBEEF);
        step_a(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check("rd10_pulse_end", 32'(d_rvalid), 32'h0);
        check("rd10_hold", 32'(d_rdata), 32'hBEEF);

        // ---- starvation guard: D wins 3 cycles, I wins the 4th ----
        for (int c = 0; c < 3; c++) begin
            step_a(1'b1, 16'h0004, 1'b1, 1'b0, 16'h0010, 16'h0000);
            check("stall_i_lose", 32'(i_gnt), 32'h0);
            check("stall_d_win", 32'(d_gnt), 32'h1);
        end
        step_a(1'b1, 16'h0004, 1'b1, 1'b0, 16'h0010, 16'h0000);
        check("stall_i_forced", 32'(i_gnt), 32'h1);
        check("stall_d_blocked", 32'(d_gnt), 32'h0);
        check("stall_d_rvalid", 32'(d_rvalid), 32'h1);
        // Counter must be clear again: D wins the next contested cycle.
        step_a(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0000, 16'h0000);
        check("stall_cleared_d", 32'(d_gnt), 32'h1);
        check("stall_cleared_i", 32'(i_gnt), 32'h0);
        check("fetch4_rvalid", 32'(i_rvalid), 32'h1);
        check("fetch4_rdata", 32'(i_rdata), 32'hA004);
        check("fetch4_no_d", 32'(d_rvalid), 32'h0);
        step_a(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check("i_alone_gnt", 32'(i_gnt), 32'h1);
        check("d0_rvalid", 32'(d_rvalid), 32'h1);
        check("d0_rdata", 32'(d_rdata), 32'hA000);
        step_a(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check("fetch10_rvalid", 32'(i_rvalid), 32'h1);
        check("fetch10_rdata", 32'(i_rdata), 32'hBEEF);

        // ---- back-to-back I fetches 0..7 ----
        for (int k = 0; k < 9; k++) begin
            if (k < 8) begin
                step_a(1'b1, 16'(k), 1'b0, 1'b0, 16'h0000, 16'h0000);
                check("b2b_gnt", 32'(i_gnt), 32'h1);
            end else begin
                step_a(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
            end
            if (k > 0) begin
                check("b2b_rvalid", 32'(i_rvalid), 32'h1);
                if (exp_q.size() > 0) begin
                    check("b2b_rdata", 32'(i_rdata), 32'(exp_q.pop_front()));
                end else begin
                    check("b2b_queue", 32'h0, 32'h1);
                end
            end
            if (k < 8) exp_q.push_back(16'hA000 + 16'(k));
        end
        step_a(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check("b2b_done", 32'(i_rvalid), 32'h0);
        check("b2b_queue_empty", 32'(exp_q.size()), 32'h0);

        // ---- out-of-range accesses ----
        step_a(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100, 16'h1234);
        check("oor_wr_gnt", 32'(d_gnt), 32'h1);
        step_a(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0100, 16'h0000);
        check("oor_wr_err", 32'(d_err), 32'h1);
        check("oor_wr_no_rvalid", 32'(d_rvalid), 32'h0);
        step_a(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000);
        check("oor_rd_rvalid", 32'(d_rvalid), 32'h1);
        check("oor_rd_zero", 32'(d_rdata), 32'h0);
        check("oor_rd_err", 32'(d_err), 32'h1);
        step_a(1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check("alias_untouched", 32'(d_rdata), 32'hA000);
        check("alias_no_err", 32'(d_err), 32'h0);
        check("i_oor_gnt", 32'(i_gnt), 32'h1);
        step_a(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check("i_oor_rvalid", 32'(i_rvalid), 32'h1);
        check("i_oor_zero", 32'(i_rdata), 32'h0);
        check("i_oor_err", 32'(i_err), 32'h1);
        check("i_oor_d_hold", 32'(d_rdata), 32'hA000);
        step_a(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check("i_err_pulse_end", 32'(i_err), 32'h0);

        // ---- asynchronous reset mid-cycle cancels a pending response ----
        step_a(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0004, 16'h0000);
        check("pre_rst_gnt", 32'(d_gnt), 32'h1);
        @(posedge clk);
        #1;
        check("pre_rst_rvalid", 32'(d_rvalid), 32'h1);
        check("pre_rst_rdata", 32'(d_rdata), 32'hA004);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_rvalid", 32'(d_rvalid), 32'h0);
        check("async_rst_rdata", 32'(d_rdata), 32'h0);
        check("async_rst_gnt", 32'(d_gnt), 32'h0);
        step_a(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check("in_rst_rvalid", 32'(d_rvalid), 32'h0);
        rst = 1'b0;
        step_a(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check("post_rst_no_rvalid", 32'(d_rvalid), 32'h0);
        step_a(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'h0000);
        check("post_rst_gnt", 32'(d_gnt), 32'h1);
        step_a(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check("ram_kept_rvalid", 32'(d_rvalid), 32'h1);
        check("ram_kept_rdata", 32'(d_rdata), 32'hBEEF);

        // ---- wide instance: DATA_W=32, DEPTH=1024 ----
        step_b(1'b1, 1'b1, 16'h03FF, 32'hDEADBEEF);
        check("w_wr_gnt", 32'(b_d_gnt), 32'h1);
        step_b(1'b1, 1'b0, 16'h03FF, 32'h0);
        check("w_rd_gnt", 32'(b_d_gnt), 32'h1);
        check("w_wr_no_err", 32'(b_d_err), 32'h0);
        step_b(1'b1, 1'b0, 16'h0400, 32'h0);
        check("w_rd_rvalid", 32'(b_d_rvalid), 32'h1);
        check("w_rd_rdata", b_d_rdata, 32'hDEADBEEF);
        check("w_rd_no_err", 32'(b_d_err), 32'h0);
        step_b(1'b0, 1'b0, 16'h0000, 32'h0);
        check("w_oor_rvalid", 32'(b_d_rvalid), 32'h1);
        check("w_oor_zero", b_d_rdata, 32'h0);
        check("w_oor_err", 32'(b_d_err), 32'h1);
        check("w_i_idle", 32'({b_i_gnt, b_i_rvalid, b_i_err}), 32'h0);
        check("w_i_rdata", b_i_rdata, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
